// File: rtl/dvp_pkg.sv
// dvp_pkg: shared types, default timing and sizing helpers for the DVP transmitter.
package dvp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } dvp_tx_state_t;

  localparam int DVP_H_ACTIVE_DEF    = 1280;
  localparam int DVP_H_BLANK_DEF     = 160;
  localparam int DVP_V_ACTIVE_DEF    = 720;
  localparam int DVP_VSYNC_LINES_DEF = 4;
  localparam int DVP_V_BACK_DEF      = 16;
  localparam int DVP_V_FRONT_DEF     = 4;

  function automatic int dvp_h_total(int ha, int hb);
    return ha + hb;
  endfunction

  function automatic int dvp_cnt_w(int mx);
    return (mx < 1) ? 1 : $clog2(mx + 1);
  endfunction

  function automatic int dvp_max4(int a, int b, int c, int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/dvp_tx_timing.sv
// dvp_tx_timing: frame FSM, h/v counters and raw timing strobes.
// h/v counters are exported only when DVP_TX_PATTERN_EN is defined.
module dvp_tx_timing
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE    = DVP_H_ACTIVE_DEF,
  parameter int H_BLANK     = DVP_H_BLANK_DEF,
  parameter int V_ACTIVE    = DVP_V_ACTIVE_DEF,
  parameter int VSYNC_LINES = DVP_VSYNC_LINES_DEF,
  parameter int V_BACK      = DVP_V_BACK_DEF,
  parameter int V_FRONT     = DVP_V_FRONT_DEF,
  localparam int H_TOTAL = dvp_h_total(H_ACTIVE, H_BLANK),
  localparam int HW = dvp_cnt_w(H_TOTAL - 1),
  localparam int VW = dvp_cnt_w(
    dvp_max4(VSYNC_LINES, V_BACK, V_ACTIVE, V_FRONT) - 1)
) (
  input  logic          PCLK,
  input  logic          Rst_n,
  input  logic          Enable,
`ifdef DVP_TX_PATTERN_EN
  output logic [HW-1:0] h_cnt_o,
  output logic [VW-1:0] v_cnt_o,
`endif
  output logic          active_o,
  output logic          vsync_o,
  output logic          line_end_o,
  output logic          frame_start_o,
  output logic          frame_end_o
);

  dvp_tx_state_t state_q;
  dvp_tx_state_t nxt;
  logic [HW-1:0] h_q;
  logic [VW-1:0] v_q;
  logic [VW-1:0] lines_m1;
  logic          line_end;
  logic          last_line;

  always_comb begin
    lines_m1 = '0;
    nxt      = state_q;
    unique case (state_q)
      ST_VSYNC: begin
        lines_m1 = VW'(VSYNC_LINES - 1);
        nxt      = ST_VBACK;
      end
      ST_VBACK: begin
        lines_m1 = VW'(V_BACK - 1);
        nxt      = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        lines_m1 = VW'(V_ACTIVE - 1);
        nxt      = ST_VFRONT;
      end
      ST_VFRONT: begin
        lines_m1 = VW'(V_FRONT - 1);
        nxt      = Enable ? ST_VSYNC : ST_IDLE;
      end
      default: ;
    endcase
  end

  assign line_end  = (state_q != ST_IDLE) &&
                     (h_q == HW'(H_TOTAL - 1));
  assign last_line = line_end && (v_q == lines_m1);

  always_ff @(posedge PCLK or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          h_q <= '0;
          v_q <= '0;
          if (Enable) state_q <= ST_VSYNC;
        end
        default: begin
          h_q <= line_end ? '0 : h_q + HW'(1);
          if (line_end)
            v_q <= last_line ? '0 : v_q + VW'(1);
          if (last_line) state_q <= nxt;
        end
      endcase
    end
  end

`ifdef DVP_TX_PATTERN_EN
  assign h_cnt_o = h_q;
  assign v_cnt_o = v_q;
`endif

  assign active_o      = (state_q == ST_ACTIVE) &&
                         (h_q < HW'(H_ACTIVE));
  assign vsync_o       = (state_q == ST_VSYNC);
  assign line_end_o    = line_end;
  assign frame_start_o = vsync_o && (h_q == '0) &&
                         (v_q == '0);
  assign frame_end_o   = (state_q == ST_VFRONT) &&
                         last_line;

endmodule

// File: rtl/dvp_tx_raw.sv
// dvp_tx_raw: valid/ready raw pixel stream to DVP Vsync/Href/Data.
// Define DVP_TX_PATTERN_EN to add the PatternSel test-pattern source.
module dvp_tx_raw
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE    = DVP_H_ACTIVE_DEF,
  parameter int H_BLANK     = DVP_H_BLANK_DEF,
  parameter int V_ACTIVE    = DVP_V_ACTIVE_DEF,
  parameter int VSYNC_LINES = DVP_VSYNC_LINES_DEF,
  parameter int V_BACK      = DVP_V_BACK_DEF,
  parameter int V_FRONT     = DVP_V_FRONT_DEF
) (
  input  logic        PCLK,
  input  logic        Rst_n,
  input  logic        Enable,
`ifdef DVP_TX_PATTERN_EN
  input  logic        PatternSel,
`endif
  input  logic        PixValid,
  input  logic [7:0]  PixData,
  output logic        PixReady,
  output logic        Vsync,
  output logic        Href,
  output logic [7:0]  Data,
  output logic        FrameStart,
  output logic        Underflow,
  output logic [15:0] FrameCnt
);

  localparam int H_TOTAL = dvp_h_total(H_ACTIVE, H_BLANK);
  localparam int HW = dvp_cnt_w(H_TOTAL - 1);
  localparam int VW = dvp_cnt_w(
    dvp_max4(VSYNC_LINES, V_BACK, V_ACTIVE, V_FRONT) - 1);

  logic act, vs, fs, fe, le_unused;

  logic        vsync_q, vsync_d;
  logic        href_q, href_d;
  logic [7:0]  data_q, data_d;
  logic        fs_q, fs_d;
  logic        unf_q, unf_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic        rdy;

`ifdef DVP_TX_PATTERN_EN
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [15:0]   psum;
  logic          pat_q, pat_d;
`endif

  dvp_tx_timing #(
    .H_ACTIVE    (H_ACTIVE),
    .H_BLANK     (H_BLANK),
    .V_ACTIVE    (V_ACTIVE),
    .VSYNC_LINES (VSYNC_LINES),
    .V_BACK      (V_BACK),
    .V_FRONT     (V_FRONT)
  ) u_timing (
    .PCLK          (PCLK),
    .Rst_n         (Rst_n),
    .Enable        (Enable),
`ifdef DVP_TX_PATTERN_EN
    .h_cnt_o       (h_cnt),
    .v_cnt_o       (v_cnt),
`endif
    .active_o      (act),
    .vsync_o       (vs),
    .line_end_o    (le_unused),
    .frame_start_o (fs),
    .frame_end_o   (fe)
  );

`ifdef DVP_TX_PATTERN_EN
  assign psum = 16'(h_cnt) + 16'(v_cnt);
  assign rdy  = act & ~pat_q;
`else
  assign rdy  = act;
`endif

  always_comb begin
    vsync_d = vs;
    href_d  = act;
    fs_d    = fs;
    data_d  = 8'h00;
    unf_d   = unf_q;
    fcnt_d  = fcnt_q;
    if (fe) fcnt_d = fcnt_q + 16'd1;
`ifdef DVP_TX_PATTERN_EN
    pat_d = fs ? PatternSel : pat_q;
    if (act && pat_q) data_d = psum[7:0];
`endif
    // missing pixels are zero-filled; line timing never stalls
    if (rdy) begin
      data_d = PixValid ? PixData : 8'h00;
      if (!PixValid) unf_d = 1'b1;
    end
  end

  always_ff @(posedge PCLK or negedge Rst_n) begin
    if (!Rst_n) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      data_q  <= 8'h00;
      fs_q    <= 1'b0;
      unf_q   <= 1'b0;
      fcnt_q  <= 16'd0;
`ifdef DVP_TX_PATTERN_EN
      pat_q   <= 1'b0;
`endif
    end else begin
      vsync_q <= vsync_d;
      href_q  <= href_d;
      data_q  <= data_d;
      fs_q    <= fs_d;
      unf_q   <= unf_d;
      fcnt_q  <= fcnt_d;
`ifdef DVP_TX_PATTERN_EN
      pat_q   <= pat_d;
`endif
    end
  end

  assign PixReady   = rdy;
  assign Vsync      = vsync_q;
  assign Href       = href_q;
  assign Data       = data_q;
  assign FrameStart = fs_q;
  assign Underflow  = unf_q;
  assign FrameCnt   = fcnt_q;

  logic unused;
  assign unused = le_unused;

endmodule

// File: tb/tb_dvp_tx_raw.sv
// tb_dvp_tx_raw: directed checks of dvp_tx_raw with small timing.
// Pattern checks run only when DVP_TX_PATTERN_EN is defined.
module tb_dvp_tx_raw;

  logic        PCLK = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Enable = 1'b0;
  logic        PixValid;
  logic [7:0]  PixData;
  logic        PixReady, Vsync, Href;
  logic        FrameStart, Underflow;
  logic [7:0]  Data;
  logic [15:0] FrameCnt;
`ifdef DVP_TX_PATTERN_EN
  logic        PatternSel = 1'b0;
`endif

  dvp_tx_raw #(
    .H_ACTIVE    (4),
    .H_BLANK     (2),
    .V_ACTIVE    (3),
    .VSYNC_LINES (1),
    .V_BACK      (1),
    .V_FRONT     (1)
  ) dut (
    .PCLK       (PCLK),
    .Rst_n      (Rst_n),
    .Enable     (Enable),
`ifdef DVP_TX_PATTERN_EN
    .PatternSel (PatternSel),
`endif
    .PixValid   (PixValid),
    .PixData    (PixData),
    .PixReady   (PixReady),
    .Vsync      (Vsync),
    .Href       (Href),
    .Data       (Data),
    .FrameStart (FrameStart),
    .Underflow  (Underflow),
    .FrameCnt   (FrameCnt)
  );

  always #5 PCLK = ~PCLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  // source: advances on every slot it was offered
  logic pend;
  int   rdy_idx;
  logic drop_en = 1'b0;
  always @(negedge PCLK) begin
    if (!Rst_n) begin
      pend     = 1'b0;
      rdy_idx  = 0;
      PixData  = 8'h00;
      PixValid = 1'b1;
    end else begin
      if (pend) PixData = PixData + 8'd1;
      pend     = PixReady;
      PixValid = !(drop_en && PixReady && rdy_idx == 5);
      if (PixReady) rdy_idx++;
    end
  end

  int         cyc, vs_n, fs_n, hr_n, rdy_n, first_hr;
  int         ovl = 0;
  int         fs_t[$];
  logic [7:0] hd[$];
  always @(negedge PCLK) begin
    if (Vsync && Href) ovl++;
    if (!Rst_n) begin
      cyc = 0; vs_n = 0; fs_n = 0;
      hr_n = 0; rdy_n = 0; first_hr = 0;
      fs_t.delete();
      hd.delete();
    end else begin
      cyc++;
      if (Vsync) vs_n++;
      if (FrameStart) begin
        fs_n++;
        fs_t.push_back(cyc);
      end
      if (Href) begin
        hr_n++;
        hd.push_back(Data);
        if (first_hr == 0) first_hr = cyc;
      end
      if (PixReady) rdy_n++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge PCLK);
      #1;
    end
  endtask

  task automatic start(input logic en);
    Rst_n  = 1'b0;
    Enable = 1'b0;
    tick(2);
    Enable = en;
    Rst_n  = 1'b1;
  endtask

  task automatic chk_ramp(input string tag);
    for (int i = 0; i < 12; i++)
      chk(tag, 32'(hd[i]), i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    tick(2);
    chk("rst_vsync", 32'(Vsync), 0);
    chk("rst_href", 32'(Href), 0);
    chk("rst_data", 32'(Data), 0);
    chk("rst_ready", 32'(PixReady), 0);
    chk("rst_fs", 32'(FrameStart), 0);
    chk("rst_unf", 32'(Underflow), 0);
    chk("rst_fcnt", 32'(FrameCnt), 0);

    // first frame and three back-to-back frames
    start(1'b1);
    tick(36);
    chk("f1_fcnt36", 32'(FrameCnt), 0);
    tick(1);
    chk("f1_fcnt37", 32'(FrameCnt), 1);
    chk("f1_fs_n", fs_n, 1);
    chk("f1_fs_t", fs_t[0], 2);
    chk("f1_vs_n", vs_n, 6);
    chk("f1_href1", first_hr, 14);
    chk("f1_hr_n", hr_n, 12);
    chk_ramp("f1_data");
    tick(72);
    chk("f3_fcnt", 32'(FrameCnt), 3);
    chk("f3_fs_n", fs_n, 3);
    chk("f3_per1", fs_t[1] - fs_t[0], 36);
    chk("f3_per2", fs_t[2] - fs_t[1], 36);
    chk("f3_vs_n", vs_n, 18);
    chk("f3_hr_n", hr_n, 36);
    chk("f3_d12", 32'(hd[12]), 12);
    chk("f3_d35", 32'(hd[35]), 35);

    // missing pixel on line 1, position 1
    drop_en = 1'b1;
    start(1'b1);
    tick(20);
    chk("uf_before", 32'(Underflow), 0);
    tick(1);
    chk("uf_set", 32'(Underflow), 1);
    tick(16);
    chk("uf_hr_n", hr_n, 12);
    chk("uf_d4", 32'(hd[4]), 4);
    chk("uf_d5", 32'(hd[5]), 0);
    chk("uf_d6", 32'(hd[6]), 6);
    chk("uf_d11", 32'(hd[11]), 11);
    chk("uf_fcnt", 32'(FrameCnt), 1);
    tick(36);
    chk("uf_sticky", 32'(Underflow), 1);
    drop_en = 1'b0;

    // Enable dropped mid-ACTIVE
    start(1'b1);
    tick(15);
    chk("en_href", 32'(Href), 1);
    Enable = 1'b0;
    tick(23);
    chk("en_hr_n", hr_n, 12);
    chk("en_fcnt", 32'(FrameCnt), 1);
    chk("en_vsync", 32'(Vsync), 0);
    chk("en_href0", 32'(Href), 0);
    chk("en_ready", 32'(PixReady), 0);
    chk("en_data", 32'(Data), 0);
    tick(10);
    chk("en_idle_fs", fs_n, 1);
    chk("en_idle_vs", vs_n, 6);
    Enable = 1'b1;
    tick(2);
    chk("en_fs", 32'(FrameStart), 1);
    chk("en_fs_n", fs_n, 2);

    // asynchronous reset mid-line
    start(1'b1);
    tick(15);
    chk("ar_href", 32'(Href), 1);
    chk("ar_data", 32'(Data), 1);
    chk("ar_ready", 32'(PixReady), 1);
    Rst_n = 1'b0;
    #1;
    chk("ar_href0", 32'(Href), 0);
    chk("ar_data0", 32'(Data), 0);
    chk("ar_ready0", 32'(PixReady), 0);
    chk("ar_vsync0", 32'(Vsync), 0);
    start(1'b1);
    tick(37);
    chk("ar_fcnt", 32'(FrameCnt), 1);
    chk("ar_fs_n", fs_n, 1);
    chk("ar_hr_n", hr_n, 12);
    chk_ramp("ar_data");

`ifdef DVP_TX_PATTERN_EN
    PatternSel = 1'b1;
    start(1'b1);
    tick(37);
    chk("pt_rdy_n", rdy_n, 0);
    chk("pt_hr_n", hr_n, 12);
    chk("pt_d0", 32'(hd[0]), 0);
    chk("pt_d4", 32'(hd[4]), 1);
    chk("pt_d8", 32'(hd[8]), 2);
    chk("pt_d9", 32'(hd[9]), 3);
    chk("pt_d10", 32'(hd[10]), 4);
    chk("pt_d11", 32'(hd[11]), 5);
    chk("pt_unf", 32'(Underflow), 0);
`endif

    chk("no_overlap", ovl, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
